// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue.
//
// Contents:
//   INSTR_W          - width of one instruction word
//   PC_START_DEFAULT - PC loaded on reset unless overridden
//   MIPS_NOP         - all-zero MIPS no-op encoding
//   pc_step()        - byte distance between consecutive fetch bundles
package fetch_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] PC_START_DEFAULT = 32'h00400020;
    localparam logic [31:0] MIPS_NOP         = 32'h00000000;

    // Each bundle holds fetch_width 4-byte words, so the PC advances by 4*fetch_width.
    function automatic logic [31:0] pc_step(input int fetch_width);
        return 32'(4 * fetch_width);
    endfunction

endpackage

// File: rtl/bundle_fifo.sv
// Synchronous FIFO holding fetched bundles.
//
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-low reset
//   push, din   - write din at the tail (ignored when full unless pop also fires)
//   pop         - advance the head (ignored when empty)
//   flush       - discard all entries; takes priority over push/pop
//   dout        - head entry, read combinationally from the storage array
//   full, empty - occupancy flags
//   count       - number of occupied entries (0..DEPTH)
module bundle_fifo #(
    parameter int DATA_W = 96,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [DATA_W-1:0]      din,
    output logic [DATA_W-1:0]      dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A push into a full FIFO is allowed only when the head leaves in the
    // same cycle; the write then lands in the slot being vacated.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    assign dout = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/ins_fetch_queue.sv
// Multi-issue instruction fetch stage with a bundle queue.
//
// Holds the PC, reads FETCH_WIDTH consecutive words per cycle from a
// combinational instruction memory and queues {pc, words} bundles so that
// decode back-pressure does not stall fetching until the queue fills.
//
// Ports:
//   clk, reset    - rising-edge clock, synchronous active-low reset
//   imem_addr     - byte address of lane 0 of the bundle being fetched (= pc)
//   imem_en       - this cycle's imem_data is written into the queue
//   imem_data     - lane i holds the word at imem_addr + 4*i
//   redirect      - taken branch/jump: flush queue, load redirect_pc
//   redirect_pc   - new PC, low two bits forced to zero
//   out_valid     - head bundle present
//   out_ready     - decode takes the head bundle this cycle
//   out_pc        - PC of lane 0 of the head bundle
//   out_instr     - head bundle words, lane 0 in the low bits
//   count         - occupied queue entries
//   full, empty   - occupancy flags
//
// Handshake: the head bundle transfers on a rising edge where
// out_valid && out_ready && !redirect. out_pc/out_instr are held stable while
// out_valid is high and the head is not taken; they are meaningless while
// out_valid is low. A redirect cancels any transfer in its cycle.
module ins_fetch_queue
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_START    = PC_START_DEFAULT,
    parameter int          FETCH_WIDTH = 2,
    parameter int          DEPTH       = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    output logic [31:0]                    imem_addr,
    output logic                           imem_en,
    input  logic [INSTR_W*FETCH_WIDTH-1:0] imem_data,
    input  logic                           redirect,
    input  logic [31:0]                    redirect_pc,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_pc,
    output logic [INSTR_W*FETCH_WIDTH-1:0] out_instr,
    output logic [$clog2(DEPTH):0]         count,
    output logic                           full,
    output logic                           empty
);

    localparam int BUNDLE_W = INSTR_W * FETCH_WIDTH;
    localparam int ENTRY_W  = 32 + BUNDLE_W;

    logic [31:0]        pc;
    logic               enq;
    logic               deq;
    logic [ENTRY_W-1:0] head;
    logic               unused_pc_lsbs;

    // Word-aligned fetch only; the byte offset of a redirect target is dropped.
    assign unused_pc_lsbs = ^redirect_pc[1:0];

    assign imem_addr = pc;
    assign out_valid = ~empty;

    // Dequeue frees a slot in the same cycle, so a full queue with decode
    // accepting still fetches.
    assign deq     = out_valid & out_ready & ~redirect;
    assign enq     = ~redirect & (~full | deq);
    assign imem_en = enq;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= PC_START;
        end else if (redirect) begin
            pc <= {redirect_pc[31:2], 2'b00};
        end else if (enq) begin
            pc <= pc + pc_step(FETCH_WIDTH);
        end
    end

    bundle_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_bundle_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (enq),
        .pop   (deq),
        .flush (redirect),
        .din   ({pc, imem_data}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign out_pc    = head[ENTRY_W-1:BUNDLE_W];
    assign out_instr = head[BUNDLE_W-1:0];

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Bench for ins_fetch_queue: dut_a (FETCH_WIDTH=2, DEPTH=4) and
// dut_b (FETCH_WIDTH=4, DEPTH=2). Memory returns the word address as data.
module tb_ins_fetch_queue;

    localparam logic [31:0] PCS = 32'h00400020;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- dut_a ----------------
    logic         a_reset, a_redirect, a_out_ready;
    logic [31:0]  a_redirect_pc, a_imem_addr, a_out_pc;
    logic         a_imem_en, a_out_valid, a_full, a_empty;
    logic [63:0]  a_imem_data, a_out_instr;
    logic [2:0]   a_count;

    always_comb a_imem_data = {a_imem_addr + 32'd4, a_imem_addr};

    ins_fetch_queue #(.PC_START(PCS), .FETCH_WIDTH(2), .DEPTH(4)) dut_a (
        .clk(clk), .reset(a_reset), .imem_addr(a_imem_addr), .imem_en(a_imem_en),
        .imem_data(a_imem_data), .redirect(a_redirect), .redirect_pc(a_redirect_pc),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc),
        .out_instr(a_out_instr), .count(a_count), .full(a_full), .empty(a_empty)
    );

    // ---------------- dut_b ----------------
    logic         b_reset, b_redirect, b_out_ready;
    logic [31:0]  b_redirect_pc, b_imem_addr, b_out_pc;
    logic         b_imem_en, b_out_valid, b_full, b_empty;
    logic [127:0] b_imem_data, b_out_instr;
    logic [1:0]   b_count;

    always_comb b_imem_data = {b_imem_addr + 32'd12, b_imem_addr + 32'd8,
                               b_imem_addr + 32'd4, b_imem_addr};

    ins_fetch_queue #(.PC_START(PCS), .FETCH_WIDTH(4), .DEPTH(2)) dut_b (
        .clk(clk), .reset(b_reset), .imem_addr(b_imem_addr), .imem_en(b_imem_en),
        .imem_data(b_imem_data), .redirect(b_redirect), .redirect_pc(b_redirect_pc),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
        .out_instr(b_out_instr), .count(b_count), .full(b_full), .empty(b_empty)
    );

    // ---------------- reference model ----------------
    // Queue of bundle PCs in fetch order; bundle contents follow from the PC
    // because the memory returns each word's own address.
    logic [31:0] ma_pc, mb_pc;
    logic [31:0] ma_q[$];
    logic [31:0] mb_q[$];

    function automatic logic [134:0] exp_a();
        int n; logic v, en; logic [31:0] h;
        n  = ma_q.size();
        v  = (n != 0);
        h  = v ? ma_q[0] : 32'h0;
        en = !a_redirect && (n < 4 || (v && a_out_ready));
        return {en, ma_pc, v, 3'(n), (n == 4), !v, h, v ? {h + 32'd4, h} : 64'h0};
    endfunction

    function automatic logic [134:0] obs_a();
        return {a_imem_en, a_imem_addr, a_out_valid, a_count, a_full, a_empty,
                a_out_valid ? a_out_pc : 32'h0, a_out_valid ? a_out_instr : 64'h0};
    endfunction

    function automatic logic [197:0] exp_b();
        int n; logic v, en; logic [31:0] h;
        n  = mb_q.size();
        v  = (n != 0);
        h  = v ? mb_q[0] : 32'h0;
        en = !b_redirect && (n < 2 || (v && b_out_ready));
        return {en, mb_pc, v, 2'(n), (n == 2), !v, h,
                v ? {h + 32'd12, h + 32'd8, h + 32'd4, h} : 128'h0};
    endfunction

    function automatic logic [197:0] obs_b();
        return {b_imem_en, b_imem_addr, b_out_valid, b_count, b_full, b_empty,
                b_out_valid ? b_out_pc : 32'h0, b_out_valid ? b_out_instr : 128'h0};
    endfunction

    // Advance the model across the coming rising edge using the driven inputs.
    task automatic model_a_step();
        int n; logic deq, enq;
        if (!a_reset) begin
            ma_pc = PCS; ma_q.delete();
        end else if (a_redirect) begin
            ma_pc = {a_redirect_pc[31:2], 2'b00}; ma_q.delete();
        end else begin
            n   = ma_q.size();
            deq = (n != 0) && a_out_ready;
            enq = (n < 4) || deq;
            if (deq) void'(ma_q.pop_front());
            if (enq) begin ma_q.push_back(ma_pc); ma_pc = ma_pc + 32'd8; end
        end
    endtask

    task automatic model_b_step();
        int n; logic deq, enq;
        if (!b_reset) begin
            mb_pc = PCS; mb_q.delete();
        end else if (b_redirect) begin
            mb_pc = {b_redirect_pc[31:2], 2'b00}; mb_q.delete();
        end else begin
            n   = mb_q.size();
            deq = (n != 0) && b_out_ready;
            enq = (n < 2) || deq;
            if (deq) void'(mb_q.pop_front());
            if (enq) begin mb_q.push_back(mb_pc); mb_pc = mb_pc + 32'd16; end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_a(input logic rst, input logic redir, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        a_reset = rst; a_redirect = redir; a_redirect_pc = rpc; a_out_ready = rdy;
        #1;
    endtask

    task automatic drive_b(input logic rst, input logic redir, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        b_reset = rst; b_redirect = redir; b_redirect_pc = rpc; b_out_ready = rdy;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive_a(1'b0, 1'b0, 32'h0, 1'b1);
            if (obs_a() !== exp_a()) begin bad++; $display("FAIL reset_model got=%h exp=%h", obs_a(), exp_a()); end
            total++;
            model_a_step();
        end
        if ({a_out_valid, a_empty, a_full, a_imem_en} !== 4'b0101) begin
            bad++; $display("FAIL reset_flags got=%b exp=0101", {a_out_valid, a_empty, a_full, a_imem_en});
        end
        total++;
        if (a_imem_addr !== PCS) begin bad++; $display("FAIL reset_addr got=%h exp=%h", a_imem_addr, PCS); end
        total++;
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 6; i++) begin
            drive_a(1'b1, 1'b0, 32'h0, 1'b1);
            if (obs_a() !== exp_a()) begin bad++; $display("FAIL free_run_model cyc=%0d got=%h exp=%h", i, obs_a(), exp_a()); end
            total++;
            if (i == 0 && a_out_valid !== 1'b0) begin bad++; $display("FAIL free_run_first_valid got=%b exp=0", a_out_valid); end
            if (i == 0) total++;
            if (i >= 1 && i <= 3 && (a_out_valid !== 1'b1 || a_out_pc !== PCS + 32'(8 * (i - 1)))) begin
                bad++; $display("FAIL free_run_pc cyc=%0d got=%h exp=%h", i, a_out_pc, PCS + 32'(8 * (i - 1)));
            end
            if (i >= 1 && i <= 3) total++;
            if (i == 1 && a_out_instr !== 64'h00400024_00400020) begin
                bad++; $display("FAIL free_run_instr got=%h exp=0040002400400020", a_out_instr);
            end
            if (i == 1) total++;
            model_a_step();
        end
    endtask

    task automatic test_backpressure();
        drive_a(1'b0, 1'b0, 32'h0, 1'b0);
        model_a_step();
        for (int i = 0; i < 10; i++) begin
            drive_a(1'b1, 1'b0, 32'h0, 1'b0);
            if (obs_a() !== exp_a()) begin bad++; $display("FAIL stall_model cyc=%0d got=%h exp=%h", i, obs_a(), exp_a()); end
            total++;
            if (i <= 4 && a_count !== 3'(i)) begin bad++; $display("FAIL stall_count cyc=%0d got=%0d exp=%0d", i, a_count, i); end
            if (i <= 4) total++;
            model_a_step();
        end
        if ({a_full, a_imem_en, a_count} !== 5'b10100 || a_imem_addr !== 32'h00400040) begin
            bad++; $display("FAIL stall_full got=%b/%h exp=10100/00400040", {a_full, a_imem_en, a_count}, a_imem_addr);
        end
        total++;
        for (int j = 0; j < 8; j++) begin
            drive_a(1'b1, 1'b0, 32'h0, 1'b1);
            if (obs_a() !== exp_a()) begin bad++; $display("FAIL drain_model cyc=%0d got=%h exp=%h", j, obs_a(), exp_a()); end
            total++;
            if (a_out_pc !== PCS + 32'(8 * j) || a_imem_en !== 1'b1 || a_count !== 3'd4) begin
                bad++; $display("FAIL drain_order cyc=%0d got=%h/%b/%0d exp=%h/1/4", j, a_out_pc, a_imem_en, a_count, PCS + 32'(8 * j));
            end
            total++;
            model_a_step();
        end
    endtask

    task automatic test_redirect();
        drive_a(1'b0, 1'b0, 32'h0, 1'b0);
        model_a_step();
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 1'b0, 32'h0, 1'b0);
            model_a_step();
        end
        drive_a(1'b1, 1'b1, 32'h00400103, 1'b1);
        if (obs_a() !== exp_a() || a_count !== 3'd3) begin bad++; $display("FAIL redir_edge got=%h exp=%h", obs_a(), exp_a()); end
        total++;
        model_a_step();
        for (int i = 0; i < 6; i++) begin
            drive_a(1'b1, 1'b0, 32'h0, 1'b1);
            if (obs_a() !== exp_a()) begin bad++; $display("FAIL redir_model cyc=%0d got=%h exp=%h", i, obs_a(), exp_a()); end
            total++;
            if (i == 0 && ({a_count, a_out_valid} !== 4'b0000 || a_imem_addr !== 32'h00400100)) begin
                bad++; $display("FAIL redir_flush got=%0d/%b/%h exp=0/0/00400100", a_count, a_out_valid, a_imem_addr);
            end
            if (i == 0) total++;
            if (i >= 1 && (a_out_valid !== 1'b1 || a_out_pc !== 32'h00400100 + 32'(8 * (i - 1)))) begin
                bad++; $display("FAIL redir_target cyc=%0d got=%h exp=%h", i, a_out_pc, 32'h00400100 + 32'(8 * (i - 1)));
            end
            if (i >= 1) total++;
            model_a_step();
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [2];
        exp_pc[0] = 32'hFFFFFFF8;
        exp_pc[1] = 32'h00000000;
        drive_a(1'b1, 1'b1, 32'hFFFFFFF8, 1'b1);
        model_a_step();
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 1'b0, 32'h0, 1'b1);
            if (obs_a() !== exp_a()) begin bad++; $display("FAIL wrap_model cyc=%0d got=%h exp=%h", i, obs_a(), exp_a()); end
            total++;
            if (i >= 1 && i <= 2 && (a_out_valid !== 1'b1 || a_out_pc !== exp_pc[i - 1])) begin
                bad++; $display("FAIL wrap_pc cyc=%0d got=%h exp=%h", i, a_out_pc, exp_pc[i - 1]);
            end
            if (i >= 1 && i <= 2) total++;
            model_a_step();
        end
    endtask

    task automatic test_reset_while_full();
        for (int i = 0; i < 6; i++) begin
            drive_a(1'b1, 1'b0, 32'h0, 1'b0);
            model_a_step();
        end
        drive_a(1'b0, 1'b1, 32'h12345678, 1'b1);
        if (obs_a() !== exp_a() || a_full !== 1'b1) begin bad++; $display("FAIL rst_full_edge got=%h exp=%h", obs_a(), exp_a()); end
        total++;
        model_a_step();
        drive_a(1'b1, 1'b0, 32'h0, 1'b1);
        if ({a_count, a_out_valid} !== 4'b0000 || a_imem_addr !== PCS) begin
            bad++; $display("FAIL rst_full_after got=%0d/%b/%h exp=0/0/%h", a_count, a_out_valid, a_imem_addr, PCS);
        end
        total++;
        if (obs_a() !== exp_a()) begin bad++; $display("FAIL rst_full_model got=%h exp=%h", obs_a(), exp_a()); end
        total++;
        model_a_step();
    endtask

    task automatic test_random();
        logic rst, redir, rdy; logic [31:0] rpc;
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 63) != 0);
            redir = ($urandom_range(0, 15) == 0);
            rdy   = ($urandom_range(0, 99) < 60);
            rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFE0 | 32'($urandom_range(0, 31))) : $urandom();
            drive_a(rst, redir, rpc, rdy);
            if (obs_a() !== exp_a()) begin bad++; $display("FAIL random_model cyc=%0d got=%h exp=%h", i, obs_a(), exp_a()); end
            total++;
            model_a_step();
        end
    endtask

    task automatic test_wide();
        logic redir, rdy; logic [31:0] rpc;
        drive_b(1'b0, 1'b0, 32'h0, 1'b0);
        if (obs_b() !== exp_b()) begin bad++; $display("FAIL wide_reset got=%h exp=%h", obs_b(), exp_b()); end
        total++;
        model_b_step();
        for (int i = 0; i < 4; i++) begin
            drive_b(1'b1, 1'b0, 32'h0, 1'b0);
            if (obs_b() !== exp_b()) begin bad++; $display("FAIL wide_fill cyc=%0d got=%h exp=%h", i, obs_b(), exp_b()); end
            total++;
            model_b_step();
        end
        if ({b_full, b_count, b_imem_en} !== 4'b1100 || b_imem_addr !== 32'h00400040) begin
            bad++; $display("FAIL wide_full got=%b/%h exp=1100/00400040", {b_full, b_count, b_imem_en}, b_imem_addr);
        end
        total++;
        for (int j = 0; j < 6; j++) begin
            drive_b(1'b1, 1'b0, 32'h0, 1'b1);
            if (b_out_pc !== PCS + 32'(16 * j) || b_out_instr[127:96] !== PCS + 32'(16 * j + 12)) begin
                bad++; $display("FAIL wide_lane3 cyc=%0d got=%h/%h exp=%h", j, b_out_pc, b_out_instr[127:96], PCS + 32'(16 * j));
            end
            total++;
            if (obs_b() !== exp_b()) begin bad++; $display("FAIL wide_drain cyc=%0d got=%h exp=%h", j, obs_b(), exp_b()); end
            total++;
            model_b_step();
        end
        for (int i = 0; i < 200; i++) begin
            redir = ($urandom_range(0, 15) == 0);
            rdy   = ($urandom_range(0, 99) < 55);
            rpc   = $urandom();
            drive_b(1'b1, redir, rpc, rdy);
            if (obs_b() !== exp_b()) begin bad++; $display("FAIL wide_random cyc=%0d got=%h exp=%h", i, obs_b(), exp_b()); end
            total++;
            model_b_step();
        end
    endtask

    initial begin
        a_reset = 1'b0; a_redirect = 1'b0; a_redirect_pc = 32'h0; a_out_ready = 1'b0;
        b_reset = 1'b0; b_redirect = 1'b0; b_redirect_pc = 32'h0; b_out_ready = 1'b0;
        // Both DUTs see reset at the first rising edge.
        model_a_step();
        model_b_step();
        test_reset();
        test_free_run();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_reset_while_full();
        test_random();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
